// File: rtl/map_arb_pkg.sv
// Shared types and defaults for the map BRAM arbiter and the map dual_port_bram instances.
package map_arb_pkg;

  localparam int unsigned MAP_DATA_WIDTH = 4;
  localparam int unsigned MAP_DATA_DEPTH = 1023;

  typedef enum logic {
    S_ARB  = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // Index width for a requester count, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester at or after ptr_i, wrapping.
module rr_arbiter
  import map_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_grant_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

  assign any_grant_o = |grant_o;

endmodule

// File: rtl/map_bram_arbiter.sv
// Round-robin sharing of map BRAM port A between game-logic requesters, plus a whole-map fill.
// Define MAP_ARB_LOCK_EN to add req_lock for atomic read-modify-write sequences.
module map_bram_arbiter
  import map_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = MAP_DATA_WIDTH,
  parameter  int unsigned DATA_DEPTH = MAP_DATA_DEPTH,
  localparam int unsigned ADDR_W     = $clog2(DATA_DEPTH),
  localparam int unsigned IDX_W      = clog2_min1(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
`ifdef MAP_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             req_lock,
`endif
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  input  logic                           fill_start,
  input  logic [DATA_WIDTH-1:0]          fill_value,
  output logic                           fill_busy,
  output logic                           fill_done,
  output logic                           bram_we,
  output logic [ADDR_W-1:0]              bram_addr,
  output logic [DATA_WIDTH-1:0]          bram_din,
  input  logic [DATA_WIDTH-1:0]          bram_dout
);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   fill_val_q, fill_val_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                    fill_done_q, fill_done_d;

  logic [ADDR_W-1:0]       addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]      arb_valid;
  logic [NUM_REQ-1:0]      grant_oh;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        rr_next;
  logic                    any_grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef MAP_ARB_LOCK_EN
  logic                    lock_q, lock_d;
  logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;
  logic                    fill_pend_q, fill_pend_d;

  // A held lock hides every other requester; it lapses as soon as the owner drops valid.
  always_comb begin
    arb_valid = req_valid;
    if (lock_q && req_valid[lock_idx_q]) begin
      arb_valid             = '0;
      arb_valid[lock_idx_q] = 1'b1;
    end
  end
`else
  assign arb_valid = req_valid;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .valid_i     (arb_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant_oh),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign rr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Next-state and combinational BRAM/handshake drive.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    fill_val_d  = fill_val_q;
    rsp_valid_d = '0;
    fill_done_d = 1'b0;
    req_ready   = '0;
    bram_we     = 1'b0;
    bram_addr   = '0;
    bram_din    = '0;
`ifdef MAP_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    fill_pend_d = fill_pend_q;
`endif

    case (state_q)
      S_ARB: begin
`ifdef MAP_ARB_LOCK_EN
        lock_d = 1'b0;
`endif
        if (any_grant) begin
          req_ready   = grant_oh;
          bram_we     = req_we[grant_idx];
          bram_addr   = addr_arr[grant_idx];
          bram_din    = wdata_arr[grant_idx];
          rsp_valid_d = grant_oh;
`ifdef MAP_ARB_LOCK_EN
          lock_d     = req_lock[grant_idx];
          lock_idx_d = grant_idx;
          if (!req_lock[grant_idx]) begin
            rr_ptr_d = rr_next;
          end
`else
          rr_ptr_d = rr_next;
`endif
        end

`ifdef MAP_ARB_LOCK_EN
        // A fill requested under lock is remembered and launched once the lock clears.
        if (fill_start) begin
          fill_val_d = fill_value;
        end
        if (fill_start || fill_pend_q) begin
          if (lock_d) begin
            fill_pend_d = 1'b1;
          end else begin
            state_d     = S_FILL;
            cnt_d       = '0;
            fill_pend_d = 1'b0;
          end
        end
`else
        if (fill_start) begin
          state_d    = S_FILL;
          cnt_d      = '0;
          fill_val_d = fill_value;
        end
`endif
      end

      S_FILL: begin
        bram_we   = 1'b1;
        bram_addr = cnt_q;
        bram_din  = fill_val_q;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DATA_DEPTH - 1)) begin
          state_d     = S_ARB;
          cnt_d       = '0;
          fill_done_d = 1'b1;
        end
      end

      default: state_d = S_ARB;
    endcase

    // Combinational drives stay quiet while reset is held.
    if (!rst_n) begin
      req_ready = '0;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_din  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ARB;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      fill_val_q  <= '0;
      rsp_valid_q <= '0;
      fill_done_q <= 1'b0;
`ifdef MAP_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      fill_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      fill_val_q  <= fill_val_d;
      rsp_valid_q <= rsp_valid_d;
      fill_done_q <= fill_done_d;
`ifdef MAP_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      fill_pend_q <= fill_pend_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = bram_dout;
  assign fill_busy = (state_q == S_FILL);
  assign fill_done = fill_done_q;

endmodule

// File: tb/tb_map_bram_arbiter.sv
// Directed bench for map_bram_arbiter with a read-first BRAM model on port A (DATA_DEPTH = 16).
module tb_map_bram_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned DD = 16;
  localparam int unsigned AW = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
`ifdef MAP_ARB_LOCK_EN
  logic [NR-1:0]     req_lock;
`endif
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              fill_start;
  logic [DW-1:0]     fill_value;
  logic              fill_busy;
  logic              fill_done;
  logic              bram_we;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_din;
  logic [DW-1:0]     bram_dout;

  logic [DW-1:0]     mem [DD];
  logic              mem_init;
  int                pass_cnt;
  int                chk_cnt;
  int                rsp_cnt [NR];

  map_bram_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef MAP_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM port: dout carries the content before this edge's write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DD; i++) mem[i] <= DW'(i);
    end else if (bram_we) begin
      mem[bram_addr] <= bram_din;
    end
    bram_dout <= mem[bram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[r]            = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pass_cnt   = 0;
    chk_cnt    = 0;
    rst_n      = 1'b0;
    mem_init   = 1'b1;
    req_valid  = '1;
    req_we     = '1;
    req_addr   = '1;
    req_wdata  = '1;
    fill_start = 1'b1;
    fill_value = '0;
`ifdef MAP_ARB_LOCK_EN
    req_lock   = '0;
`endif
    #1;
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_bram_we", 32'(bram_we), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_fill_busy", 32'(fill_busy), 32'(0));
    chk("rst_fill_done", 32'(fill_done), 32'(0));
    chk("rst_bram_addr", 32'(bram_addr), 32'(0));

    @(negedge clk);
    mem_init   = 1'b0;
    fill_start = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    rst_n      = 1'b1;

    // Write 0x5 @10, then read it back; mem[10] starts as 0xA.
    @(negedge clk);
    set_req(0, 1'b1, AW'(10), DW'(5));
    req_valid = 4'b0001;
    #1;
    chk("wr_ready", 32'(req_ready), 32'(4'b0001));
    chk("wr_bram_we", 32'(bram_we), 32'(1));
    chk("wr_bram_addr", 32'(bram_addr), 32'(10));
    chk("wr_bram_din", 32'(bram_din), 32'(5));
    chk("wr_no_rsp_yet", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    set_req(0, 1'b0, AW'(10), DW'(0));
    #1;
    chk("rd_ready", 32'(req_ready), 32'(4'b0001));
    chk("rd_bram_we", 32'(bram_we), 32'(0));
    chk("wr_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    chk("wr_rsp_old", 32'(rsp_rdata), 32'(4'hA));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    chk("rd_rsp_data", 32'(rsp_rdata), 32'(4'h5));
    chk("idle_ready", 32'(req_ready), 32'(0));
    chk("idle_bram_addr", 32'(bram_addr), 32'(0));
    @(negedge clk);
    #1;
    chk("idle_rsp", 32'(rsp_valid), 32'(0));

    // Fairness: all four valid for 8 cycles from reset; requester r reads addr r+1.
    do_reset();
    for (int r = 0; r < NR; r++) begin
      set_req(r, 1'b0, AW'(r + 1), DW'(0));
      rsp_cnt[r] = 0;
    end
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) chk($sformatf("fair_grant%0d", k), 32'(req_ready), 32'(1) << (k % 4));
      if (k > 0) begin
        chk($sformatf("fair_rsp%0d", k), 32'(rsp_valid), 32'(1) << ((k - 1) % 4));
        chk($sformatf("fair_data%0d", k), 32'(rsp_rdata), 32'((k - 1) % 4 + 1));
      end
      for (int r = 0; r < NR; r++) if (rsp_valid[r]) rsp_cnt[r]++;
    end
    for (int r = 0; r < NR; r++) chk($sformatf("fair_count%0d", r), 32'(rsp_cnt[r]), 32'(2));

    // Sparse: rr_ptr is back at 0, only requesters 2 and 3 valid.
    @(negedge clk);
    req_valid = 4'b1100;
    #1;
    chk("sparse_g0", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    #1;
    chk("sparse_g1", 32'(req_ready), 32'(4'b1000));
    chk("sparse_rsp0", 32'(rsp_valid), 32'(4'b0100));
    @(negedge clk);
    #1;
    chk("sparse_g2", 32'(req_ready), 32'(4'b0100));
    chk("sparse_rsp1", 32'(rsp_valid), 32'(4'b1000));

    // Fill with 0x0: the read issued alongside fill_start is still granted and answered.
    @(negedge clk);
    set_req(1, 1'b0, AW'(3), DW'(0));
    req_valid  = 4'b0010;
    fill_start = 1'b1;
    fill_value = 4'h0;
    #1;
    chk("fill_start_grant", 32'(req_ready), 32'(4'b0010));
    chk("fill_start_busy", 32'(fill_busy), 32'(0));
    for (int k = 0; k < DD; k++) begin
      @(negedge clk);
      fill_start = (k == 3);
      fill_value = (k == 3) ? 4'h7 : 4'h0;
      req_valid  = 4'hF;
      #1;
      chk($sformatf("fill_busy%0d", k), 32'(fill_busy), 32'(1));
      chk($sformatf("fill_ready%0d", k), 32'(req_ready), 32'(0));
      chk($sformatf("fill_we%0d", k), 32'(bram_we), 32'(1));
      chk($sformatf("fill_addr%0d", k), 32'(bram_addr), 32'(k));
      chk($sformatf("fill_din%0d", k), 32'(bram_din), 32'(0));
      chk($sformatf("fill_done_early%0d", k), 32'(fill_done), 32'(0));
      if (k == 0) begin
        chk("fill_inflight_rsp", 32'(rsp_valid), 32'(4'b0010));
        chk("fill_inflight_data", 32'(rsp_rdata), 32'(3));
      end
    end
    @(negedge clk);
    fill_start = 1'b0;
    #1;
    chk("fill_done_pulse", 32'(fill_done), 32'(1));
    chk("fill_busy_drop", 32'(fill_busy), 32'(0));
    chk("post_fill_grant", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("fill_done_clear", 32'(fill_done), 32'(0));
    chk("post_fill_rsp", 32'(rsp_valid), 32'(4'b0100));
    for (int a = 0; a <= DD; a++) begin
      @(negedge clk);
      if (a < DD) begin
        set_req(0, 1'b0, AW'(a), DW'(0));
        req_valid = 4'b0001;
      end else begin
        req_valid = '0;
      end
      #1;
      if (a > 0) begin
        chk($sformatf("filled_rsp%0d", a - 1), 32'(rsp_valid), 32'(4'b0001));
        chk($sformatf("filled_data%0d", a - 1), 32'(rsp_rdata), 32'(0));
      end
    end

    // Reset during fill cycle 5 (addr 0..4 already hold 0xF).
    @(negedge clk);
    fill_start = 1'b1;
    fill_value = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      #1;
      chk($sformatf("rfill_addr%0d", k), 32'(bram_addr), 32'(k));
    end
    @(negedge clk);
    #1;
    chk("rfill_addr5", 32'(bram_addr), 32'(5));
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("rfill_busy", 32'(fill_busy), 32'(0));
    chk("rfill_we", 32'(bram_we), 32'(0));
    chk("rfill_ready", 32'(req_ready), 32'(0));
    chk("rfill_rsp", 32'(rsp_valid), 32'(0));
    chk("rfill_done", 32'(fill_done), 32'(0));
    chk("rfill_addr_zero", 32'(bram_addr), 32'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    #1;
    chk("rfill_no_done", 32'(fill_done), 32'(0));
    @(negedge clk);
    set_req(1, 1'b0, AW'(2), DW'(0));
    req_valid = 4'b0010;
    #1;
    chk("rfill_req1_grant", 32'(req_ready), 32'(4'b0010));
    chk("rfill_no_done2", 32'(fill_done), 32'(0));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rfill_req1_rsp", 32'(rsp_valid), 32'(4'b0010));
    chk("rfill_req1_data", 32'(rsp_rdata), 32'(4'hF));

`ifdef MAP_ARB_LOCK_EN
    // Lock: req1 reads @7 locked while req0 waits; its unlocked write @7 goes next, then req0.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b0, AW'(1), DW'(0));
    set_req(1, 1'b0, AW'(7), DW'(0));
    req_lock  = 4'b0010;
    req_valid = 4'b0010;
    #1;
    chk("lock_first_grant", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    set_req(1, 1'b1, AW'(7), DW'(9));
    req_lock  = 4'b0000;
    req_valid = 4'b0011;
    #1;
    chk("lock_held_grant", 32'(req_ready), 32'(4'b0010));
    chk("lock_held_din", 32'(bram_din), 32'(9));
    chk("lock_read_rsp", 32'(rsp_valid), 32'(4'b0010));
    chk("lock_read_data", 32'(rsp_rdata), 32'(0));
    @(negedge clk);
    #1;
    chk("lock_release_grant", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = '0;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
